// File: rtl/skullfet_tester_pkg.sv
// Shared definitions for the SkullFET cell tester.
//   state_t    : tester FSM states
//   CELL_INV   : cell_type bit value for an inverter channel
//   CELL_NAND  : cell_type bit value for a NAND channel
//   PAT_W      : width of the (B,A) stimulus pattern
//   expected_y : ideal Y for a cell of the given type driven with A and B
package skullfet_tester_pkg;

  localparam int   PAT_W     = 2;
  localparam logic CELL_INV  = 1'b0;
  localparam logic CELL_NAND = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  function automatic logic expected_y(input logic cell_type, input logic a, input logic b);
    return (cell_type == CELL_NAND) ? ~(a & b) : ~a;
  endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Generic-width two-flop synchronizer with asynchronous active-high reset.
//   i_clk : destination clock
//   i_rst : asynchronous reset, active-high, clears both flop stages
//   i_d   : asynchronous input bus
//   o_q   : synchronized output bus (two clock latency)
module skullfet_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta_p0;
  logic [WIDTH-1:0] r_sync_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      // stage p0: may go metastable; stage p1: resolved copy
      r_meta_p0 <= i_d;
      r_sync_p1 <= r_meta_p0;
    end
  end

  assign o_q = r_sync_p1;

endmodule

// File: rtl/skullfet_cell_tester.sv
// SkullFET cell tester: drives the four (B,A) patterns 00,01,10,11 onto every
// channel, waits SETTLE cycles, samples each cell's synchronized Y and counts
// mismatches against the ideal inverter / NAND response, for a configurable
// number of sweeps.
//
// Parameters: CHANNELS (cells under test), SETTLE (settle cycles, 2..15),
//             ERR_W (width of each saturating error counter).
// Ports:
//   wb_clk_i     : clock
//   wb_rst_i     : asynchronous active-high reset
//   start_i      : start a run (looked at only in IDLE)
//   passes_i     : number of sweeps, 0 means 1 (latched at start)
//   cell_type_i  : per channel 0 = inverter, 1 = NAND (latched at start)
//   cell_a_o     : cell input A per channel
//   cell_b_o     : cell input B per channel
//   cell_y_i     : cell output Y per channel (asynchronous)
//   busy_o       : run in progress (DRIVE/SETTLE/SAMPLE)
//   done_o       : one-cycle pulse in the DONE cycle
//   pass_o       : all counters zero at end of run, held until next start
//   err_cnt_o    : channel n count at [n*ERR_W +: ERR_W]
//   fail_vld_o   : (SKULLFET_TESTER_FAILCAP_EN only) channel has failed this run
//   fail_pat_o   : (SKULLFET_TESTER_FAILCAP_EN only) first failing (B,A) per channel
//
// Build option: define SKULLFET_TESTER_FAILCAP_EN to add the first-fail capture.
module skullfet_cell_tester
  import skullfet_tester_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 3,
  parameter int ERR_W    = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      start_i,
  input  logic [3:0]                passes_i,
  input  logic [CHANNELS-1:0]       cell_type_i,
  output logic [CHANNELS-1:0]       cell_a_o,
  output logic [CHANNELS-1:0]       cell_b_o,
  input  logic [CHANNELS-1:0]       cell_y_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [CHANNELS*ERR_W-1:0] err_cnt_o
`ifdef SKULLFET_TESTER_FAILCAP_EN
  ,
  output logic [CHANNELS-1:0]       fail_vld_o,
  output logic [2*CHANNELS-1:0]     fail_pat_o
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [3:0]                  r_settle_cnt;
  logic [PAT_W-1:0]            r_pat;
  logic [PAT_W-1:0]            w_pat_nxt;
  logic [3:0]                  r_sweep;
  logic [3:0]                  r_passes;
  logic [CHANNELS-1:0]         r_type;
  logic [CHANNELS-1:0]         r_a;
  logic [CHANNELS-1:0]         r_b;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_pass;
  logic [CHANNELS*ERR_W-1:0]   r_err;
  logic [CHANNELS*ERR_W-1:0]   w_err_nxt;
  logic [CHANNELS-1:0]         w_y_sync;
  logic [CHANNELS-1:0]         w_mis;
  logic                        w_settle_last;
  logic                        w_last_pat;
  logic                        w_run_end;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  skullfet_sync2 #(
    .WIDTH(CHANNELS)
  ) u_sync_y (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_d   (cell_y_i),
    .o_q   (w_y_sync)
  );

  assign w_settle_last = (r_settle_cnt == SETTLE_LAST);
  assign w_last_pat    = (r_pat == {PAT_W{1'b1}});
  // r_passes is at least 1 once a run has started
  assign w_run_end     = w_last_pat && (r_sweep == (r_passes - 4'd1));
  assign w_pat_nxt     = r_pat + PAT_W'(1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_last) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_run_end ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Compare synchronized Y with the ideal response of the driven pattern.
  always_comb begin
    w_mis     = '0;
    w_err_nxt = r_err;
    for (int n = 0; n < CHANNELS; n++) begin
      w_mis[n] = w_y_sync[n] ^ expected_y(r_type[n], r_a[n], r_b[n]);
      if (w_mis[n]) w_err_nxt[n*ERR_W +: ERR_W] = sat_inc(r_err[n*ERR_W +: ERR_W]);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_settle_cnt <= '0;
      r_pat        <= '0;
      r_sweep      <= '0;
      r_passes     <= '0;
      r_type       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
    end else begin
      // flags track the state being entered so they line up with it
      r_done <= (w_state_nxt == ST_DONE);
      r_busy <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                (w_state_nxt == ST_SAMPLE);
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_passes     <= (passes_i == 4'd0) ? 4'd1 : passes_i;
            r_type       <= cell_type_i;
            r_pat        <= '0;
            r_sweep      <= '0;
            r_settle_cnt <= '0;
            r_a          <= '0;
            r_b          <= '0;
          end
        end
        ST_SETTLE: r_settle_cnt <= w_settle_last ? 4'd0 : r_settle_cnt + 4'd1;
        ST_SAMPLE: begin
          r_err <= w_err_nxt;
          r_pat <= w_pat_nxt;
          if (w_last_pat) r_sweep <= r_sweep + 4'd1;
          if (w_run_end) begin
            r_pass <= (w_err_nxt == '0);
            r_a    <= '0;
            r_b    <= '0;
          end else begin
            // present the next pattern as DRIVE is entered
            r_a <= {CHANNELS{w_pat_nxt[0]}};
            r_b <= {CHANNELS{w_pat_nxt[1]}};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SKULLFET_TESTER_FAILCAP_EN
  logic [CHANNELS-1:0]   r_fail_vld;
  logic [2*CHANNELS-1:0] r_fail_pat;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_fail_vld <= '0;
      r_fail_pat <= '0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_fail_vld <= '0;
      r_fail_pat <= '0;
    end else if (r_state == ST_SAMPLE) begin
      for (int n = 0; n < CHANNELS; n++) begin
        // keep only the first failing pattern of the run
        if (w_mis[n] && !r_fail_vld[n]) begin
          r_fail_vld[n]                 <= 1'b1;
          r_fail_pat[n*PAT_W +: PAT_W]  <= r_pat;
        end
      end
    end
  end

  assign fail_vld_o = r_fail_vld;
  assign fail_pat_o = r_fail_pat;
`else
  // first-fail capture not built
`endif

  assign cell_a_o  = r_a;
  assign cell_b_o  = r_b;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign err_cnt_o = r_err;

endmodule

// File: tb/tb_skullfet_cell_tester.sv
// Bench for skullfet_cell_tester. Two instances share clock and reset:
//   A: CHANNELS=4, SETTLE=3, ERR_W=8
//   B: CHANNELS=4, SETTLE=2, ERR_W=2
// Pad models per channel: 0 ideal, 1 Y stuck at 0, 2 Y inverted,
// 3 Y wrong only for A=B=1. Expected run results are queued at start and
// compared when done_o pulses.
module tb_skullfet_cell_tester;

  typedef struct packed {
    logic [15:0] cyc;
    logic        pass;
    logic [31:0] err;   // 8 bits per channel
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [3:0]  passes_a, passes_b, type_a, type_b;
  logic [7:0]  modes_a, modes_b;
  logic [3:0]  ca_a, cb_a, y_a, ca_b, cb_b, y_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [31:0] err_a;
  logic [7:0]  err_b;
`ifdef SKULLFET_TESTER_FAILCAP_EN
  logic [3:0]  fvld_a, fvld_b;
  logic [7:0]  fpat_a, fpat_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b, last_a;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_a = 0, cyc_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  skullfet_cell_tester #(.CHANNELS(4), .SETTLE(3), .ERR_W(8)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .passes_i(passes_a),
    .cell_type_i(type_a), .cell_a_o(ca_a), .cell_b_o(cb_a), .cell_y_i(y_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a)
`ifdef SKULLFET_TESTER_FAILCAP_EN
    , .fail_vld_o(fvld_a), .fail_pat_o(fpat_a)
`endif
  );

  skullfet_cell_tester #(.CHANNELS(4), .SETTLE(2), .ERR_W(2)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .passes_i(passes_b),
    .cell_type_i(type_b), .cell_a_o(ca_b), .cell_b_o(cb_b), .cell_y_i(y_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b)
`ifdef SKULLFET_TESTER_FAILCAP_EN
    , .fail_vld_o(fvld_b), .fail_pat_o(fpat_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pad_y(input logic t, input logic [1:0] m, input logic a, input logic b);
    logic id;
    id = t ? ~(a & b) : ~a;
    case (m)
      2'd0:    return id;
      2'd1:    return 1'b0;
      2'd2:    return ~id;
      default: return (a & b) ? ~id : id;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] types, input logic [7:0] modes,
                                 input logic [3:0] passes, input int settle, input int errw);
    exp_t e;
    int   cnt[4];
    int   np, maxv;
    logic a, b, ideal;
    np   = (passes == 4'd0) ? 1 : int'(passes);
    maxv = (1 << errw) - 1;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int s = 0; s < np; s++)
      for (int p = 0; p < 4; p++) begin
        a = p[0];
        b = p[1];
        for (int c = 0; c < 4; c++) begin
          ideal = types[c] ? ~(a & b) : ~a;
          if (pad_y(types[c], modes[2*c +: 2], a, b) !== ideal && cnt[c] < maxv) cnt[c]++;
        end
      end
    e.cyc = 16'(np * 4 * (settle + 2));
    e.err = '0;
    for (int c = 0; c < 4; c++) e.err[c*8 +: 8] = 8'(cnt[c]);
    e.pass = (e.err == '0);
    return e;
  endfunction

  function automatic logic [7:0] shrink2(input logic [31:0] w);
    logic [7:0] r;
    for (int c = 0; c < 4; c++) r[c*2 +: 2] = w[c*8 +: 2];
    return r;
  endfunction

  always_comb begin
    y_a = '0;
    y_b = '0;
    for (int c = 0; c < 4; c++) begin
      y_a[c] = pad_y(type_a[c], modes_a[2*c +: 2], ca_a[c], cb_a[c]);
      y_b[c] = pad_y(type_b[c], modes_b[2*c +: 2], ca_b[c], cb_b[c]);
    end
  end

  always @(negedge clk) begin
    if (rst) cyc_a = 0;
    else begin
      if (busy_a) cyc_a++;
      if (done_a) begin
        if (q_a.size() == 0) check_eq("A spurious done_o", 64'd1, 64'd0);
        else begin
          e_a = q_a.pop_front();
          check_eq("A run cycles", 64'(cyc_a), 64'(e_a.cyc));
          check_eq("A pass_o", 64'(pass_a), 64'(e_a.pass));
          check_eq("A err_cnt_o", 64'(err_a), 64'(e_a.err));
          check_eq("A cells low in DONE", 64'({ca_a, cb_a}), 64'd0);
          check_eq("A busy_o low in DONE", 64'(busy_a), 64'd0);
        end
        cyc_a = 0;
        done_cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) cyc_b = 0;
    else begin
      if (busy_b) cyc_b++;
      if (done_b) begin
        if (q_b.size() == 0) check_eq("B spurious done_o", 64'd1, 64'd0);
        else begin
          e_b = q_b.pop_front();
          check_eq("B run cycles", 64'(cyc_b), 64'(e_b.cyc));
          check_eq("B pass_o", 64'(pass_b), 64'(e_b.pass));
          check_eq("B err_cnt_o", 64'(err_b), 64'(shrink2(e_b.err)));
        end
        cyc_b = 0;
        done_cnt_b++;
      end
    end
  end

  task automatic start_a_run(input logic [3:0] types, input logic [7:0] modes, input logic [3:0] passes);
    type_a   = types;
    modes_a  = modes;
    passes_a = passes;
    last_a   = model(types, modes, passes, 3, 8);
    q_a.push_back(last_a);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check_eq("A busy_o after start", 64'(busy_a), 64'd1);
  endtask

  task automatic start_b_run(input logic [3:0] types, input logic [7:0] modes, input logic [3:0] passes);
    type_b   = types;
    modes_b  = modes;
    passes_b = passes;
    q_b.push_back(model(types, modes, passes, 2, 2));
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  task automatic wait_a(input int base);
    for (int i = 0; i < 3000 && done_cnt_a == base; i++) @(negedge clk);
    if (done_cnt_a == base) check_eq("A done_o timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_b(input int base);
    for (int i = 0; i < 3000 && done_cnt_b == base; i++) @(negedge clk);
    if (done_cnt_b == base) check_eq("B done_o timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    passes_a = '0; passes_b = '0; type_a = '0; type_b = '0;
    modes_a = '0; modes_b = '0;
    repeat (3) @(negedge clk);
    check_eq("A reset busy_o", 64'(busy_a), 64'd0);
    check_eq("A reset done_o", 64'(done_a), 64'd0);
    check_eq("A reset pass_o", 64'(pass_a), 64'd0);
    check_eq("A reset err_cnt_o", 64'(err_a), 64'd0);
    check_eq("A reset cell a/b", 64'({ca_a, cb_a}), 64'd0);
    check_eq("B reset err_cnt_o", 64'(err_b), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ideal cells, mixed types, one sweep
    base = done_cnt_a;
    start_a_run(4'b0101, 8'h00, 4'd1);
    wait_a(base);

    // channel 2 inverter stuck at 0, two sweeps; counts must hold in IDLE
    base = done_cnt_a;
    start_a_run(4'b1010, 8'h10, 4'd2);
    wait_a(base);
    repeat (4) @(negedge clk);
    check_eq("A err held in IDLE", 64'(err_a), 64'(last_a.err));
    check_eq("A pass_o held in IDLE", 64'(pass_a), 64'(last_a.pass));

    // reset in sweep 1 SETTLE (pattern 01) aborts the run
    type_a = 4'b1010; modes_a = 8'h10; passes_a = 4'd2;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("A ch2 count before abort", 64'(err_a[23:16]), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("A abort busy_o", 64'(busy_a), 64'd0);
    check_eq("A abort cell a/b", 64'({ca_a, cb_a}), 64'd0);
    check_eq("A abort err_cnt_o", 64'(err_a), 64'd0);
    check_eq("A abort done_o", 64'(done_a), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all NAND, channel 1 fails only on pattern 11, three sweeps
    base = done_cnt_a;
    start_a_run(4'b1111, 8'h0C, 4'd3);
    wait_a(base);
`ifdef SKULLFET_TESTER_FAILCAP_EN
    check_eq("A fail_vld_o", 64'(fvld_a), 64'b0010);
    check_eq("A fail_pat_o ch1", 64'(fpat_a[3:2]), 64'b11);
`endif

    // ERR_W=2: channel 0 inverted for 15 sweeps saturates at 3
    base = done_cnt_b;
    start_b_run(4'b0000, 8'h02, 4'd15);
    wait_b(base);

    // passes=0 runs one sweep; start and passes changes while busy are ignored
    base = done_cnt_b;
    start_b_run(4'b0000, 8'h00, 4'd0);
    repeat (5) @(negedge clk);
    passes_b = 4'd7;
    start_b  = 1'b1;
    @(negedge clk) start_b = 1'b0;
    wait_b(base);
    repeat (20) @(negedge clk);
    check_eq("B idle after single run", 64'(busy_b), 64'd0);
    check_eq("B one done_o only", 64'(done_cnt_b - base), 64'd1);

    check_eq("A scoreboard drained", 64'(q_a.size()), 64'd0);
    check_eq("B scoreboard drained", 64'(q_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
